ring_counter_ext: RTL
=====================

RING_COUNTER_EXT -- requirements
Module: ring_counter_ext

Interface
REQ-001 Parameter WIDTH, default 4, number of state bits; legal range 2..32.
REQ-002 Derived constant PW = clog2(2*WIDTH), width of pos.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  advance enable; one step per cycle while high.
REQ-006 dir  input  1  direction: 0 = shift right (toward bit 0), 1 = shift left.
REQ-007 mode_in  input  1  mode request, sampled only at rst or load: 0 = ring (one-hot), 1 = Johnson (twisted ring).
REQ-008 load  input  1  synchronous parallel load request.
REQ-009 load_val  input  WIDTH  value for load.
REQ-010 count  output  WIDTH  registered counter state.
REQ-011 pos  output  PW  registered position index of count.
REQ-012 mode  output  1  registered active mode.
REQ-013 wrap  output  1  registered one-cycle pulse, high in the cycle count returns to its home pattern by advancing.
REQ-014 load_err  output  1  registered one-cycle pulse flagging a rejected load.

Function
REQ-015 Priority per cycle: rst > load > en; en low with no load holds all state, wrap = 0, load_err = 0.
REQ-016 Home pattern: ring = one in bit 0, zeros elsewhere; Johnson = all zeros; pos = 0 at home.
REQ-017 Ring advance: dir=0 rotates right (bit 0 -> bit WIDTH-1), pos <= (pos-1) mod WIDTH; dir=1 rotates left (bit WIDTH-1 -> bit 0), pos <= (pos+1) mod WIDTH.
REQ-018 Ring pos equals the index of the single set bit of count.
REQ-019 Johnson advance: dir=0 shifts right, inverted bit 0 enters bit WIDTH-1, pos <= (pos+1) mod 2*WIDTH; dir=1 shifts left, inverted bit WIDTH-1 enters bit 0, pos <= (pos-1) mod 2*WIDTH.
REQ-020 Johnson pos equals the number of dir=0 steps from all-zeros to count (0..2*WIDTH-1).
REQ-021 dir may change any cycle; takes effect on that cycle's advance; wrap applies to either direction.
REQ-022 wrap = 1 on the cycle after an advance whose result is the home pattern; never set by rst or load.
REQ-023 Legal load value, ring: exactly one bit set.
REQ-024 Legal load value, Johnson: a contiguous run of ones touching bit WIDTH-1 or bit 0 (includes all-zeros and all-ones).
REQ-025 Legality is checked against mode_in, not the current mode.
REQ-026 Legal load: count <= load_val, mode <= mode_in, pos <= index computed per REQ-018/REQ-020, load_err <= 0, no advance that cycle.
REQ-027 Illegal load: count, pos, mode unchanged, no advance, load_err <= 1 for one cycle.
REQ-028 count is never illegal for the active mode in normal operation; pos and count always consistent.
REQ-029 No combinational path from inputs to outputs.

Reset
REQ-030 On rst: mode <= mode_in, count <= home pattern of that mode, pos <= 0, wrap <= 0, load_err <= 0.
REQ-031 rst mid-operation overrides simultaneous load and en in the same cycle.

Verification (WIDTH=4)
REQ-032 rst with mode_in=0, then en=1, dir=0 for 4 cycles -> count 1000, 0100, 0010, 0001; pos 3, 2, 1, 0; wrap high only on 4th cycle.
REQ-033 rst with mode_in=1, then en=1, dir=0 for 8 cycles -> count 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000; pos 1..7, 0; wrap only on 8th cycle.
REQ-034 Johnson at 1100 (pos 2), dir=1 one cycle -> 1000 pos 1; then en=0 for 3 cycles -> count held, wrap 0.
REQ-035 Ring mode: load=1, en=1, load_val=0100 -> count 0100, pos 2, no advance; then load_val=0110 -> count stays 0100, load_err pulses 1 cycle.
REQ-036 Ring mode: load=1, mode_in=1, load_val=0111 -> mode 1, count 0111, pos 5; then en, dir=0 -> 0011, pos 6.
REQ-037 Mid-count: rst=1 with load=1, en=1, mode_in=1 -> count 0000, pos 0, mode 1, wrap 0, load_err 0.

Source files
------------

// File: rtl/ring_counter_ext.sv
// Ring / Johnson counter with direction control, parallel load with legality check,
// and a position index that always tracks the counter pattern.
module ring_counter_ext #(
   parameter int WIDTH = 4,
   localparam int PW = $clog2(2 * WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             mode_in,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic [PW-1:0]    pos,
   output logic             mode,
   output logic             wrap,
   output logic             load_err
);

   localparam logic [PW-1:0] RING_LAST = PW'(WIDTH - 1);
   localparam logic [PW-1:0] JOHN_LAST = PW'(2 * WIDTH - 1);
   localparam logic [PW-1:0] POS_ONE   = PW'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic [PW-1:0]    pos_q, pos_d;
   logic             mode_q, mode_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;

   function automatic logic [WIDTH-1:0] homeOf(input logic m);
      return m ? '0 : WIDTH'(1);
   endfunction

   // Ring needs exactly one set bit; Johnson needs a run of ones anchored at either end,
   // i.e. the value or its complement has the form 2^k-1.
   function automatic logic isLegal(input logic m, input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] nv;
      nv = ~v;
      if (!m) return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
      return ((v & (v + WIDTH'(1))) == '0) || ((nv & (nv + WIDTH'(1))) == '0);
   endfunction

   function automatic logic [PW-1:0] posOf(input logic m, input logic [WIDTH-1:0] v);
      int ones;
      int idx;
      ones = 0;
      idx  = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) begin
            ones = ones + 1;
            idx  = i;
         end
      end
      if (!m) return PW'(idx);
      if (v[WIDTH-1]) return PW'(ones);
      if (ones == 0) return '0;
      return PW'(2 * WIDTH - ones);
   endfunction

   always_comb begin
      count_d = count_q;
      pos_d   = pos_q;
      mode_d  = mode_q;
      wrap_d  = 1'b0;
      err_d   = 1'b0;
      if (load) begin
         if (isLegal(mode_in, load_val)) begin
            count_d = load_val;
            mode_d  = mode_in;
            pos_d   = posOf(mode_in, load_val);
         end else begin
            err_d = 1'b1;
         end
      end else if (en) begin
         if (!mode_q) begin
            if (!dir) begin
               count_d = {count_q[0], count_q[WIDTH-1:1]};
               pos_d   = (pos_q == '0) ? RING_LAST : pos_q - POS_ONE;
            end else begin
               count_d = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
               pos_d   = (pos_q == RING_LAST) ? '0 : pos_q + POS_ONE;
            end
         end else begin
            if (!dir) begin
               count_d = {~count_q[0], count_q[WIDTH-1:1]};
               pos_d   = (pos_q == JOHN_LAST) ? '0 : pos_q + POS_ONE;
            end else begin
               count_d = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
               pos_d   = (pos_q == '0) ? JOHN_LAST : pos_q - POS_ONE;
            end
         end
         wrap_d = (count_d == homeOf(mode_q));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= mode_in;
         count_q <= homeOf(mode_in);
         pos_q   <= '0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         count_q <= count_d;
         pos_q   <= pos_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
      end
   end

   assign count    = count_q;
   assign pos      = pos_q;
   assign mode     = mode_q;
   assign wrap     = wrap_q;
   assign load_err = err_q;

endmodule
